// File: rtl/alu_seq_multiplier.sv
// Iterative shift-add unsigned multiplier with a valid/ready handshake on both sides.
// Each BUSY cycle, a bank of 2*WIDTH mux2to1 cells picks 0 or the shifted multiplicand
// based on the current multiplier LSB, and that selection is added into the accumulator.

// Single-bit 2:1 select cell; one instance per product bit.
module mux2to1 (
  input  logic sel_i,
  input  logic in0_i,
  input  logic in1_i,
  output logic out_o
);
  assign out_o = sel_i ? in1_i : in0_i;
endmodule

module alu_seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    prod_q, prod_d;

  logic [PW-1:0]    partial;
  logic [PW-1:0]    sum;

  // Partial-product select bank: bit i is either 0 or mcand[i].
  for (genvar i = 0; i < PW; i++) begin : g_pp
    mux2to1 u_mux (
      .sel_i (mplier_q[0]),
      .in0_i (1'b0),
      .in1_i (mcand_q[i]),
      .out_o (partial[i])
    );
  end

  // The shifted multiplicand never exceeds 2*WIDTH bits, so the sum cannot overflow.
  assign sum = acc_q + partial;

  // Next-state logic: load operands in IDLE, one shift-add per BUSY cycle, hold in DONE.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, op_a};
          mplier_d = op_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // Fixed WIDTH iterations, no early exit on zero operands.
        if (cnt_q == CW'(WIDTH - 1)) begin
          prod_d  = sum;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; async reset discards any in-flight operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
    end
  end

  // Outputs depend only on registers, never directly on inputs.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign out_valid = (state_q == DONE);
  assign product   = prod_q;

endmodule

// File: doc/alu_seq_multiplier.md
Name: alu_seq_multiplier

Overview:
- Iterative shift-add unsigned multiplier for the custom ALU datapath.
- Sits directly downstream of the mux2to1 primitive: each iteration, a WIDTH*2-wide bank of mux2to1 instances selects 0 or the shifted multiplicand from the current multiplier LSB. This block accumulates those selections into the product.
- Uses a valid/ready handshake on input and output so the core can stall on it.

Parameters:
- WIDTH, 8: operand width in bits; product is 2*WIDTH bits. Legal range is 2 to 32.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands on op_a/op_b are valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- op_a  input  WIDTH  multiplicand, unsigned
- op_b  input  WIDTH  multiplier, unsigned
- out_valid  output  1  product valid (high only in DONE)
- out_ready  input  1  consumer takes the product
- product  output  2*WIDTH  op_a*op_b, unsigned, registered
- busy  output  1  high in BUSY state

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous and active-low.
- Reset, asserted at any time including mid-operation:
  - State goes to IDLE and all internal registers clear.
  - product=0, out_valid=0, busy=0, in_ready=1 (combinational from IDLE).
  - An in-flight operation is discarded with no output.
- Registers:
  - mcand, 2*WIDTH bits
  - mplier, WIDTH bits
  - acc, 2*WIDTH bits
  - cnt, ceil(log2(WIDTH+1)) bits
  - state: IDLE, BUSY, DONE (2-bit encoding)
  - product register
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1: mcand={WIDTH zeros, op_a}, mplier=op_b, acc=0, cnt=0, go to BUSY.
  - With in_valid=0: remain in IDLE.
- BUSY, one iteration per cycle:
  - partial = mplier[0] ? mcand : 0, built from 2*WIDTH mux2to1 instances with sel=mplier[0], in0=0, in1=mcand[i].
  - acc <= acc + partial, truncated to 2*WIDTH bits. Overflow is impossible by construction.
  - mcand <= mcand<<1; mplier <= mplier>>1; cnt <= cnt+1.
  - When cnt==WIDTH-1: load product <= acc+partial, go to DONE.
  - in_ready=0; in_valid, op_a and op_b are ignored.
- DONE:
  - out_valid=1; product is held stable.
  - On a clock edge with out_ready=1: go to IDLE, out_valid drops. product keeps its value.
  - With out_ready=0: remain in DONE indefinitely.
  - in_ready=0, so there is no accept in the same cycle as the output handshake.
- Latency:
  - Acceptance at edge E0; out_valid rises after edge E_WIDTH (exactly WIDTH cycles).
  - Fixed latency with no early termination, including for zero operands.
  - Minimum initiation interval is WIDTH+2 cycles when out_ready is held high.
- Boundaries:
  - Operands of 0 give product 0 after the full latency.
  - All-ones operands give (2^WIDTH-1)^2 with no truncation.
  - in_valid held high through BUSY/DONE does not start a second operation until IDLE is re-entered. It is accepted on the first IDLE edge.
  - out_ready asserted outside DONE has no effect.
- Outputs are registers or decodes of the state register only: no combinational path from any input to any output.

Test Plan:
- Basic: WIDTH=8, reset released, op_a=13, op_b=11, in_valid for 1 cycle, out_ready=1 -> out_valid rises exactly 8 cycles after accept; product=143; back to IDLE, in_ready=1 the next cycle.
- Max and zero: op_a=255, op_b=255 -> product=65025 (0xFE01). op_a=0, op_b=200 -> product=0, also after 8 cycles.
- Backpressure: 7*9 with out_ready=0 for 5 cycles after out_valid -> out_valid and product=63 held stable all 5 cycles; IDLE one cycle after out_ready=1.
- Ignore-while-busy: accept 3*5, then pulse in_valid with 100*100 during BUSY -> result is 15. in_valid held high afterwards -> 100*100 accepted in the first IDLE cycle, giving 10000.
- Async reset mid-BUSY: reset_n low at cycle 4 of a 200*3 operation, asynchronously between edges -> product=0, out_valid=0, busy=0 immediately. After release, a new 6*7 gives 42 with no residue.
- Back-to-back: 20 random pairs with out_ready=1 -> every product matches the reference model; initiation interval is 10 cycles.
